// File: rtl/me_sad_row_engine.sv
// Motion-estimation row SAD engine: 8 horizontal candidates, 16 rows per search, best-candidate pick.
// Optional macro SAD_ALL_OUT_EN adds the sad_all port carrying every candidate's final accumulator.
module me_sad_row_engine #(
  parameter int PIX_W  = 8,
  parameter int BLK_H  = 16,
  parameter int N_CAND = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         row_valid,
  input  logic [(N_CAND+15)*PIX_W-1:0] ref_row,
  input  logic [16*PIX_W-1:0]          cur_row,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(N_CAND)-1:0]    best_idx,
  output logic [15:0]                  best_sad
`ifdef SAD_ALL_OUT_EN
  ,
  output logic [16*N_CAND-1:0]         sad_all
`endif
);

  localparam int CUR_PIX = 16;
  localparam int REF_PIX = N_CAND + CUR_PIX - 1;
  localparam int PIX_MAX = (1 << PIX_W) - 1;
  localparam int ROW_W   = $clog2(CUR_PIX * PIX_MAX + 1);
  localparam int ACC_W   = 16;
  localparam int IDX_W   = $clog2(N_CAND);
  localparam int CNT_W   = $clog2(BLK_H + 1);
  localparam int N_NODE  = 2 * N_CAND - 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_CMP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  row_cnt_q;
  logic              s1_valid_q;
  logic [ROW_W-1:0]  s1_sad_q [N_CAND];
  logic [ACC_W-1:0]  acc_q    [N_CAND];
  logic              done_q;
  logic [IDX_W-1:0]  best_idx_q;
  logic [ACC_W-1:0]  best_sad_q;
`ifdef SAD_ALL_OUT_EN
  logic [16*N_CAND-1:0] sad_all_q;
`endif

  logic              accept, clear, cmp_en;
  logic [PIX_W-1:0]  ref_px     [REF_PIX];
  logic [PIX_W-1:0]  cur_px     [CUR_PIX];
  logic [ROW_W-1:0]  row_sad_c  [N_CAND];
  logic [ACC_W-1:0]  node_val   [N_NODE];
  logic [IDX_W-1:0]  node_idx   [N_NODE];

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Pixel 0 sits in the most significant byte of each row bus.
  for (genvar gi = 0; gi < REF_PIX; gi++) begin : g_ref_px
    assign ref_px[gi] = ref_row[(REF_PIX-gi)*PIX_W-1 -: PIX_W];
  end
  for (genvar gi = 0; gi < CUR_PIX; gi++) begin : g_cur_px
    assign cur_px[gi] = cur_row[(CUR_PIX-gi)*PIX_W-1 -: PIX_W];
  end

  always_comb begin
    for (int k = 0; k < N_CAND; k++) begin
      row_sad_c[k] = '0;
      for (int j = 0; j < CUR_PIX; j++)
        row_sad_c[k] = row_sad_c[k] + ROW_W'(abs_diff(ref_px[k+j], cur_px[j]));
    end
  end

  // Heap-ordered min tree: leaves are the accumulators, a right child wins only on strictly smaller value.
  always_comb begin
    for (int n = 0; n < N_CAND; n++) begin
      node_val[N_CAND-1+n] = acc_q[n];
      node_idx[N_CAND-1+n] = IDX_W'(n);
    end
    for (int n = N_CAND - 2; n >= 0; n--) begin
      if (node_val[2*n+2] < node_val[2*n+1]) begin
        node_val[n] = node_val[2*n+2];
        node_idx[n] = node_idx[2*n+2];
      end else begin
        node_val[n] = node_val[2*n+1];
        node_idx[n] = node_idx[2*n+1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    clear   = 1'b0;
    cmp_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (row_valid) begin
          accept = 1'b1;
          if (row_cnt_q == CNT_W'(BLK_H - 1))
            state_d = S_DRAIN;
        end
      end
      // Only the last row is still in S1 here; it lands in the accumulators on this edge.
      S_DRAIN: state_d = S_CMP;
      S_CMP: begin
        cmp_en  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      done_q     <= 1'b0;
      best_idx_q <= '0;
      best_sad_q <= '1;
      for (int k = 0; k < N_CAND; k++) begin
        s1_sad_q[k] <= '0;
        acc_q[k]    <= '0;
      end
`ifdef SAD_ALL_OUT_EN
      sad_all_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      s1_valid_q <= accept;
      done_q     <= cmp_en;
      if (clear)
        row_cnt_q <= '0;
      else if (accept)
        row_cnt_q <= row_cnt_q + 1'b1;
      for (int k = 0; k < N_CAND; k++) begin
        if (accept)
          s1_sad_q[k] <= row_sad_c[k];
        if (clear)
          acc_q[k] <= '0;
        else if (s1_valid_q)
          acc_q[k] <= acc_q[k] + ACC_W'(s1_sad_q[k]);
      end
      if (cmp_en) begin
        best_idx_q <= node_idx[0];
        best_sad_q <= node_val[0];
`ifdef SAD_ALL_OUT_EN
        for (int k = 0; k < N_CAND; k++)
          sad_all_q[16*N_CAND-1-16*k -: 16] <= acc_q[k];
`endif
      end
    end
  end

  assign busy     = (state_q != S_IDLE) || done_q;
  assign done     = done_q;
  assign best_idx = best_idx_q;
  assign best_sad = best_sad_q;
`ifdef SAD_ALL_OUT_EN
  assign sad_all  = sad_all_q;
`endif

endmodule

// File: tb/tb_me_sad_row_engine.sv
// Scoreboard bench for me_sad_row_engine: expected search results queued at stimulus time, compared on done.
module tb_me_sad_row_engine;

  logic         clk = 1'b0;
  logic         rst, start, row_valid;
  logic [183:0] ref_row;
  logic [127:0] cur_row;
  logic         busy, done;
  logic [2:0]   best_idx;
  logic [15:0]  best_sad;
`ifdef SAD_ALL_OUT_EN
  logic [127:0] sad_all;
`endif

  typedef struct {
    int          idx;
    int          sad;
    logic [15:0] all [8];
  } exp_t;

  exp_t       exp_q [$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         chain_cyc = 0;
  logic [7:0] rpx [16][23];
  logic [7:0] cpx [16][16];

  me_sad_row_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .row_valid (row_valid),
    .ref_row   (ref_row),
    .cur_row   (cur_row),
    .busy      (busy),
    .done      (done),
    .best_idx  (best_idx),
    .best_sad  (best_sad)
`ifdef SAD_ALL_OUT_EN
    ,
    .sad_all   (sad_all)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Scoreboard side: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("best_idx", int'(best_idx), mon_e.idx);
        check("best_sad", int'(best_sad), mon_e.sad);
`ifdef SAD_ALL_OUT_EN
        for (int k = 0; k < 8; k++)
          check($sformatf("sad_all_%0d", k), int'(sad_all[127-16*k -: 16]), int'(mon_e.all[k]));
`endif
        $display("search done at cycle %0d: idx=%0d sad=%0d (expected idx=%0d sad=%0d)",
                 cyc, best_idx, best_sad, mon_e.idx, mon_e.sad);
      end
    end
  end

  task automatic fill_rows(input int mode);
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 23; i++) begin
        case (mode)
          0:       rpx[r][i] = 8'(i);
          1:       rpx[r][i] = 8'hFF;
          2:       rpx[r][i] = (i >= 7) ? 8'(10 + r) : 8'(11 + r);
          default: rpx[r][i] = 8'($urandom_range(0, 255));
        endcase
      end
      for (int j = 0; j < 16; j++) begin
        case (mode)
          0:       cpx[r][j] = 8'(3 + j);
          1:       cpx[r][j] = 8'h00;
          2:       cpx[r][j] = 8'(10 + r);
          default: cpx[r][j] = 8'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  task automatic push_exp(input int mode);
    exp_t e;
    int   s [8];
    int   best;
    int   a, b;
    for (int k = 0; k < 8; k++) begin
      s[k] = 0;
      for (int r = 0; r < 16; r++)
        for (int j = 0; j < 16; j++) begin
          a = int'(rpx[r][k+j]);
          b = int'(cpx[r][j]);
          s[k] += (a > b) ? a - b : b - a;
        end
      e.all[k] = 16'(s[k]);
    end
    best = 0;
    for (int k = 1; k < 8; k++)
      if (s[k] < s[best]) best = k;
    case (mode)
      0:       begin e.idx = 3; e.sad = 0;     end
      1:       begin e.idx = 0; e.sad = 65280; end
      2:       begin e.idx = 7; e.sad = 0;     end
      default: begin e.idx = best; e.sad = s[best]; end
    endcase
    exp_q.push_back(e);
  endtask

  task automatic drive_row(input int r);
    for (int i = 0; i < 23; i++) ref_row[183-8*i -: 8] = rpx[r][i];
    for (int j = 0; j < 16; j++) cur_row[127-8*j -: 8] = cpx[r][j];
  endtask

  task automatic do_search(input int mode, input bit gapped, input bit extra_starts,
                           input bit chain, input bit already_started);
    int start_cyc, last_cyc, acc, k, waitn;
    fill_rows(mode);
    push_exp(mode);
    if (!already_started) begin
      @(negedge clk);
      start     = 1'b1;
      row_valid = 1'b0;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
    end else begin
      start_cyc = chain_cyc;
    end
    acc = 0;
    k   = 0;
    last_cyc = cyc;
    while (acc < 16) begin
      row_valid = gapped ? ((k % 2) == 0) : 1'b1;
      if (row_valid) drive_row(acc);
      else begin
        ref_row = {6{$urandom()}};
        cur_row = {4{$urandom()}};
      end
      start = extra_starts && (acc == 5);
      check("busy_accum", int'(busy), 1);
      if (row_valid) begin
        last_cyc = cyc;
        acc++;
      end
      k++;
      @(negedge clk);
    end
    row_valid = 1'b0;
    start     = 1'b0;
    if (extra_starts) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    waitn = 0;
    while (done !== 1'b1 && waitn < 40) begin
      check("busy_drain", int'(busy), 1);
      @(negedge clk);
      waitn++;
    end
    if (done !== 1'b1) begin
      check("done_timeout", 0, 1);
    end else begin
      check("done_after_last_row", cyc - last_cyc, 3);
      if (!gapped) check("done_after_start", cyc - start_cyc, 19);
      check("busy_at_done", int'(busy), 1);
      if (chain) begin
        start     = 1'b1;
        chain_cyc = cyc;
      end
      @(negedge clk);
      start = 1'b0;
      check("busy_after_done", int'(busy), int'(chain));
    end
  endtask

  task automatic reset_mid();
    fill_rows(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 9; r++) begin
      row_valid = 1'b1;
      drive_row(r);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_best_sad", int'(best_sad), 16'hFFFF);
    check("rst_best_idx", int'(best_idx), 0);
`ifdef SAD_ALL_OUT_EN
    check("rst_sad_all_zero", int'(sad_all == '0), 1);
`endif
    @(negedge clk);
    rst       = 1'b0;
    row_valid = 1'b0;
    repeat (25) @(negedge clk);
    check("idle_after_rst", int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; row_valid = 1'b0;
    ref_row = '0; cur_row = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_best_idx", int'(best_idx), 0);
    check("reset_best_sad", int'(best_sad), 16'hFFFF);
`ifdef SAD_ALL_OUT_EN
    check("reset_sad_all_zero", int'(sad_all == '0), 1);
`endif
    rst = 1'b0;
    @(negedge clk);

    do_search(0, 1'b0, 1'b0, 1'b0, 1'b0);  // match at offset 3
    do_search(1, 1'b0, 1'b0, 1'b0, 1'b0);  // max-value tie
    do_search(0, 1'b1, 1'b0, 1'b0, 1'b0);  // gapped input
    do_search(2, 1'b0, 1'b1, 1'b1, 1'b0);  // late winner, ignored starts, start with done
    do_search(3, 1'b0, 1'b0, 1'b0, 1'b1);  // random rows, started in the done cycle
    reset_mid();
    do_search(0, 1'b0, 1'b0, 1'b0, 1'b0);  // fresh search after abort
    do_search(3, 1'b1, 1'b0, 1'b0, 1'b0);  // random gapped

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
